// File: rtl/subleq_mem_arbiter_if.sv
// Bus bundle between the SUBLEQ CPU datapath, the debug/loader port,
// the memory arbiter and the single-port memory macro.
interface subleq_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   // CPU datapath side
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_lock;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   // Debug/loader side
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   // Watchdog status
   logic              lock_err;

   // Memory macro side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter view: requests come in, grants and memory controls go out
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output lock_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment view: requesters and memory macro
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  lock_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/subleq_mem_arbiter.sv
// Round-robin arbiter sharing the single-port SUBLEQ memory between the
// CPU datapath and the debug/loader port. The CPU may lock ownership to
// keep a read-modify-write of mem[b] atomic; a watchdog breaks a lock
// that holds the debug port off for LOCK_MAX cycles.
module subleq_mem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int LOCK_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   subleq_mem_arbiter_if.slave  bus
);

   localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   // State
   logic             r_locked;
   logic [CNT_W-1:0] r_lock_cnt;
   logic             r_last_cpu;    // 1: CPU won last, 0: debug won last
   owner_e           r_rd_owner;
   logic             r_lock_err;

   // Next-state and combinational outputs
   logic             w_locked_nxt;
   logic [CNT_W-1:0] w_lock_cnt_nxt;
   logic             w_last_cpu_nxt;
   owner_e           w_rd_owner_nxt;
   logic             w_cpu_gnt;
   logic             w_dbg_gnt;
   logic             w_wd_expire;
   logic             w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   assign w_wd_expire = r_locked && (r_lock_cnt == CNT_LAST);

   // State register: lock, watchdog counter, round-robin pointer, read owner
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_locked   <= 1'b0;
         r_lock_cnt <= '0;
         r_last_cpu <= 1'b0;
         r_rd_owner <= OWN_NONE;
         r_lock_err <= 1'b0;
      end else begin
         r_locked   <= w_locked_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_last_cpu <= w_last_cpu_nxt;
         r_rd_owner <= w_rd_owner_nxt;
         r_lock_err <= w_wd_expire;
      end
   end

   // Grant decision: lock excludes debug, lone requester wins, else round-robin
   always_comb begin
      w_cpu_gnt = 1'b0;
      w_dbg_gnt = 1'b0;
      if (r_locked) begin
         w_cpu_gnt = bus.cpu_req;
      end else if (bus.cpu_req && bus.dbg_req) begin
         w_cpu_gnt = ~r_last_cpu;
         w_dbg_gnt = r_last_cpu;
      end else begin
         w_cpu_gnt = bus.cpu_req;
         w_dbg_gnt = bus.dbg_req;
      end
   end

   // Next state: watchdog expiry overrides any lock request in the same cycle
   always_comb begin
      w_locked_nxt   = r_locked;
      w_lock_cnt_nxt = r_lock_cnt;
      w_last_cpu_nxt = r_last_cpu;
      if (w_wd_expire) begin
         w_locked_nxt   = 1'b0;
         w_lock_cnt_nxt = '0;
         w_last_cpu_nxt = 1'b1;      // debug port wins the next conflict
      end else begin
         if (w_cpu_gnt) begin
            w_locked_nxt   = bus.cpu_lock;
            w_last_cpu_nxt = 1'b1;
         end else if (w_dbg_gnt) begin
            w_last_cpu_nxt = 1'b0;
         end else begin
            w_last_cpu_nxt = r_last_cpu;
         end
         if (r_locked) begin
            w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
         end else begin
            w_lock_cnt_nxt = '0;
         end
      end

      if (w_cpu_gnt && !bus.cpu_we) begin
         w_rd_owner_nxt = OWN_CPU;
      end else if (w_dbg_gnt && !bus.dbg_we) begin
         w_rd_owner_nxt = OWN_DBG;
      end else begin
         w_rd_owner_nxt = OWN_NONE;
      end
   end

   // Memory port mux: the granted requester drives the macro this cycle
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_cpu_gnt) begin
         w_mem_we    = bus.cpu_we;
         w_mem_addr  = bus.cpu_addr;
         w_mem_wdata = bus.cpu_wdata;
      end else if (w_dbg_gnt) begin
         w_mem_we    = bus.dbg_we;
         w_mem_addr  = bus.dbg_addr;
         w_mem_wdata = bus.dbg_wdata;
      end else begin
         w_mem_we    = 1'b0;
         w_mem_addr  = '0;
         w_mem_wdata = '0;
      end
   end

   assign bus.cpu_gnt    = w_cpu_gnt;
   assign bus.dbg_gnt    = w_dbg_gnt;
   assign bus.mem_en     = w_cpu_gnt | w_dbg_gnt;
   assign bus.mem_we     = w_mem_we;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.mem_wdata  = w_mem_wdata;
   assign bus.cpu_rvalid = (r_rd_owner == OWN_CPU);
   assign bus.dbg_rvalid = (r_rd_owner == OWN_DBG);
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dbg_rdata  = bus.mem_rdata;
   assign bus.lock_err   = r_lock_err;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Self-checking bench for subleq_mem_arbiter: directed scenarios plus
// randomized traffic, checked against a transaction-level reference model
// with a shadow memory.
module tb_subleq_mem_arbiter;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 8;
   localparam int LOCK_MAX = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   subleq_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   subleq_mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LOCK_MAX(LOCK_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Memory macro: synchronous single-port RAM, read data one cycle later
   logic [DATA_W-1:0] macro_mem [0:255];
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) macro_mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= macro_mem[bus.mem_addr];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (transaction level)
   bit              m_locked;     // CPU currently owns the memory
   int              m_age;        // cycles spent locked, including this one
   bit              m_cpu_turn;   // CPU wins the next conflict
   int              m_rv_owner;   // 0 none, 1 cpu, 2 dbg
   logic [7:0]      m_rv_data;
   bit              m_err_due;
   logic [7:0]      ref_mem [0:255];

   // Last observed DUT outputs (sampled at negedge)
   logic obs_cpu_gnt, obs_dbg_gnt, obs_cpu_rvalid, obs_dbg_rvalid, obs_lock_err;
   logic [7:0] obs_dbg_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked   = 1'b0;
      m_age      = 0;
      m_cpu_turn = 1'b1;
      m_rv_owner = 0;
      m_rv_data  = 8'h00;
      m_err_due  = 1'b0;
   endtask

   task automatic clear_inputs();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00;
      bus.cpu_wdata = 8'h00; bus.cpu_lock = 1'b0;
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00;
      bus.dbg_wdata = 8'h00;
   endtask

   // One clock cycle: check outputs at negedge, advance model, step past posedge
   task automatic tick();
      int   winner;   // 0 none, 1 cpu, 2 dbg
      bit   expire;
      bit   nxt_lock;
      logic exp_we;
      logic [7:0] exp_addr, exp_wdata;
      @(negedge clk);
      if (m_locked) winner = bus.cpu_req ? 1 : 0;
      else if (bus.cpu_req && bus.dbg_req) winner = m_cpu_turn ? 1 : 2;
      else if (bus.cpu_req) winner = 1;
      else if (bus.dbg_req) winner = 2;
      else winner = 0;

      case (winner)
         1: begin exp_we = bus.cpu_we; exp_addr = bus.cpu_addr; exp_wdata = bus.cpu_wdata; end
         2: begin exp_we = bus.dbg_we; exp_addr = bus.dbg_addr; exp_wdata = bus.dbg_wdata; end
         default: begin exp_we = 1'b0; exp_addr = 8'h00; exp_wdata = 8'h00; end
      endcase

      obs_cpu_gnt    = bus.cpu_gnt;
      obs_dbg_gnt    = bus.dbg_gnt;
      obs_cpu_rvalid = bus.cpu_rvalid;
      obs_dbg_rvalid = bus.dbg_rvalid;
      obs_lock_err   = bus.lock_err;
      obs_dbg_rdata  = bus.dbg_rdata;

      check("cpu_gnt",    bus.cpu_gnt,   32'(winner == 1));
      check("dbg_gnt",    bus.dbg_gnt,   32'(winner == 2));
      check("mem_en",     bus.mem_en,    32'(winner != 0));
      check("mem_we",     bus.mem_we,    exp_we);
      check("mem_addr",   bus.mem_addr,  exp_addr);
      check("mem_wdata",  bus.mem_wdata, exp_wdata);
      check("cpu_rvalid", bus.cpu_rvalid, 32'(m_rv_owner == 1));
      check("dbg_rvalid", bus.dbg_rvalid, 32'(m_rv_owner == 2));
      check("lock_err",   bus.lock_err,  m_err_due);
      if (m_rv_owner == 1) check("cpu_rdata", bus.cpu_rdata, m_rv_data);
      if (m_rv_owner == 2) check("dbg_rdata", bus.dbg_rdata, m_rv_data);

      // Advance the model by one cycle
      expire     = m_locked && (m_age == LOCK_MAX);
      m_rv_owner = 0;
      nxt_lock   = m_locked;
      if (winner == 1) begin
         if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
         else begin m_rv_owner = 1; m_rv_data = ref_mem[bus.cpu_addr]; end
         nxt_lock   = bus.cpu_lock;
         m_cpu_turn = 1'b0;
      end else if (winner == 2) begin
         if (bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wdata;
         else begin m_rv_owner = 2; m_rv_data = ref_mem[bus.dbg_addr]; end
         m_cpu_turn = 1'b1;
      end
      if (expire) begin
         nxt_lock   = 1'b0;
         m_cpu_turn = 1'b0;
      end
      m_age     = nxt_lock ? m_age + 1 : 0;
      m_locked  = nxt_lock;
      m_err_due = expire;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      model_reset();
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      int blocked;
      bit seen;
      bit cpu_pend, dbg_pend;
      int lockpct;
      bit exp_cpu_pat [4];

      rst = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      do_reset();

      // Preload through the debug port: 0x11,0x22,0x33,0x44,... at 0..15
      for (int i = 0; i < 16; i++) begin
         bus.dbg_req = 1'b1; bus.dbg_we = 1'b1;
         bus.dbg_addr = 8'(i); bus.dbg_wdata = 8'(8'h11 * (i + 1));
         tick();
         check("preload_gnt", obs_dbg_gnt, 32'h1);
      end
      bus.dbg_we = 1'b0; bus.dbg_addr = 8'h02;
      tick();
      bus.dbg_req = 1'b0;
      tick();
      check("dbg_rd2_valid", obs_dbg_rvalid, 32'h1);
      check("dbg_rd2_data",  obs_dbg_rdata,  32'h33);
      check("dbg_rd2_cpuv",  obs_cpu_rvalid, 32'h0);

      // Both requesters hold reads: CPU, DBG, CPU, DBG
      do_reset();
      exp_cpu_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h01;
      bus.dbg_req = 1'b1; bus.dbg_addr = 8'h03;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_cpu_gnt", obs_cpu_gnt, 32'(exp_cpu_pat[i]));
      end
      clear_inputs();
      tick();

      // Locked read-modify-write of addr 5 holds the debug port off
      do_reset();
      bus.dbg_req = 1'b1; bus.dbg_addr = 8'h07;
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h05; bus.cpu_lock = 1'b1;
      tick();
      check("rmw_t0_dbg", obs_dbg_gnt, 32'h0);
      bus.cpu_req = 1'b0;
      tick();
      check("rmw_t1_dbg", obs_dbg_gnt, 32'h0);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hA5; bus.cpu_lock = 1'b0;
      tick();
      check("rmw_t2_dbg", obs_dbg_gnt, 32'h0);
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      tick();
      check("rmw_t3_dbg", obs_dbg_gnt, 32'h1);
      bus.dbg_req = 1'b0;
      tick();

      // Stuck lock: watchdog breaks it after LOCK_MAX cycles
      do_reset();
      bus.dbg_req = 1'b1; bus.dbg_addr = 8'h05;
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h04; bus.cpu_lock = 1'b1;
      tick();
      bus.cpu_req = 1'b0; bus.cpu_lock = 1'b0;
      blocked = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (obs_lock_err) begin
            seen = 1'b1;
            check("wd_dbg_gnt_after", obs_dbg_gnt, 32'h1);
         end else if (!obs_dbg_gnt) begin
            blocked++;
         end
      end
      check("wd_seen", 32'(seen), 32'h1);
      check("wd_blocked_cycles", 32'(blocked), 32'(LOCK_MAX));
      bus.dbg_req = 1'b0;
      tick();
      check("wd_err_pulse", obs_lock_err, 32'h0);

      // CPU keeps relocking every cycle: watchdog still wins, debug gets in
      do_reset();
      bus.dbg_req = 1'b1; bus.dbg_addr = 8'h06;
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h08; bus.cpu_lock = 1'b1;
      for (int i = 0; i < LOCK_MAX + 3; i++) tick();
      clear_inputs();
      tick();

      // Reset while a CPU read is in flight: no rvalid afterwards
      do_reset();
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h03;
      @(negedge clk);
      check("inflight_gnt", bus.cpu_gnt, 32'h1);
      #2;
      rst = 1'b0;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("inflight_dropped", obs_cpu_rvalid, 32'h0);
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h02;
      bus.dbg_req = 1'b1; bus.dbg_addr = 8'h09;
      tick();
      check("post_rst_conflict", obs_cpu_gnt, 32'h1);
      clear_inputs();
      tick();

      // Randomized traffic obeying hold-until-grant
      cpu_pend = 1'b0;
      dbg_pend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         lockpct = ((c / 500) % 2 == 1) ? 90 : 30;
         if (!cpu_pend) begin
            bus.cpu_req   = ($urandom_range(0, 99) < 60);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = 8'($urandom_range(0, 15));
            bus.cpu_wdata = 8'($urandom);
            bus.cpu_lock  = ($urandom_range(0, 99) < lockpct);
         end
         if (!dbg_pend) begin
            bus.dbg_req   = ($urandom_range(0, 99) < 50);
            bus.dbg_we    = 1'($urandom_range(0, 1));
            bus.dbg_addr  = 8'($urandom_range(0, 15));
            bus.dbg_wdata = 8'($urandom);
         end
         tick();
         cpu_pend = bus.cpu_req && !obs_cpu_gnt;
         dbg_pend = bus.dbg_req && !obs_dbg_gnt;
      end
      clear_inputs();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/subleq_mem_arbiter.md
Name: subleq_mem_arbiter

Overview:
Shares the single-port program/data memory between the SUBLEQ CPU datapath (operand fetch, mem[a]/mem[b] reads, writeback) and a debug/loader port that preloads programs and inspects memory. Arbitration is round-robin, with a CPU lock that keeps the read-modify-write of mem[b] atomic. A watchdog breaks a stuck lock. Sits between the CPU datapath/control and the memory macro.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory word width
LOCK_MAX, 16, max consecutive cycles the lock may hold off the debug port (≥2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request
cpu_we  input  1  1=write, 0=read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_lock  input  1  keep ownership after this access (RMW)
cpu_gnt  output  1  CPU access accepted this cycle (combinational)
cpu_rvalid  output  1  CPU read data valid (cycle after granted read)
cpu_rdata  output  DATA_W  CPU read data
dbg_req  input  1  debug/loader access request
dbg_we  input  1  1=write, 0=read
dbg_addr  input  ADDR_W  debug address
dbg_wdata  input  DATA_W  debug write data
dbg_gnt  output  1  debug access accepted this cycle (combinational)
dbg_rvalid  output  1  debug read data valid
dbg_rdata  output  DATA_W  debug read data
lock_err  output  1  one-cycle pulse: lock forcibly broken by watchdog
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid cycle after read issue

Behaviour:
- Reset (rst=0, async): locked=0, lock_cnt=0, last_winner=DBG, rd_owner=none; cpu_rvalid=dbg_rvalid=lock_err=0. Outputs are combinational from these, so gnt/mem_* are 0 while no request is present. An in-flight read is dropped: no rvalid after reset release.
- Max one access issued per cycle. A granted requester's addr/we/wdata drive mem_* combinationally in the same cycle; mem_en=cpu_gnt|dbg_gnt; mem_we=granted we. No request: mem_en=0, mem_* other fields 0.
- Grant rules, in priority order:
  1) locked=1: only CPU may be granted; dbg_gnt=0.
  2) only one requester: grant it.
  3) both: grant the one ≠ last_winner (round-robin); update last_winner on every grant.
- Requesters hold req/addr/we/wdata stable until gnt is seen. A request without gnt is simply retried the next cycle.
- Read latency 1: a granted read (we=0) registers rd_owner. The next cycle asserts the owner's rvalid for exactly 1 cycle. cpu_rdata=dbg_rdata=mem_rdata, meaningful only with the matching rvalid. Writes produce no rvalid. Back-to-back reads from alternating owners each get exactly one rvalid, in order.
- Lock: on a CPU grant, locked←cpu_lock, so cpu_lock=1 sets or keeps the lock and cpu_lock=0 releases it after that access. Lock does not block CPU.
- Watchdog: lock_cnt increments each cycle locked=1 and is cleared when locked=0. When locked=1 and lock_cnt reaches LOCK_MAX-1:
  - next edge: locked←0, lock_cnt←0, lock_err pulses 1 cycle, last_winner←CPU so the debug port wins the next conflict.
  - If that same cycle a CPU grant with cpu_lock=1 occurs, the watchdog wins: locked=0.
- Simultaneous CPU release (cpu_lock=0 grant) and watchdog expiry: locked=0, and lock_err still pulses.
- Address/data widths pass through unmodified; no arithmetic on addresses.

Test Plan:
- Reset then dbg_we=1 writes to addr 0..3 (data 0x11,0x22,0x33,0x44), cpu idle → dbg_gnt=1 each cycle, mem_we=1, mem_addr=0..3. Then dbg read addr 2 → dbg_rvalid next cycle with dbg_rdata=0x33, cpu_rvalid=0.
- cpu_req and dbg_req both held high, reads, 4 cycles after reset → grants CPU, DBG, CPU, DBG. rvalid sequence matches one cycle later.
- CPU read addr 5 with cpu_lock=1, dbg_req high throughout, CPU write addr 5 with cpu_lock=0 two cycles later → dbg_gnt=0 until the cycle after the CPU write, then dbg_gnt=1.
- CPU grant with cpu_lock=1 then cpu_req=0, dbg_req=1, LOCK_MAX=16 → dbg_gnt=0 for 16 cycles, lock_err=1 for one cycle, dbg_gnt=1 on the following cycle.
- CPU read granted, rst pulled low before the next edge → cpu_rvalid never asserts. All outputs 0 during reset. First conflict after release grants CPU.
